// File: rtl/rv32i_inst_decoder.sv
// ---------------------------------------------------------------------------
// rv32i_inst_decoder
//   Registered RV32I decode stage between fetch and register-read/execute.
//   The instruction is decoded combinationally from inst_b and every output
//   is captured on the next rising clk edge (one-cycle latency).
//
// Ports
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   stall             1 = hold every output register
//   inst_valid        inst_b carries a real instruction
//   inst_b[31:0]      instruction word
//   out_valid         registered inst_valid
//   src1_reg/src2_reg rs1/rs2 numbers, 0 when the field is unused
//   dst_reg           rd number, 0 when there is no rd field
//   imm[31:0]         decoded, sign/zero-extended immediate, 0 if none
//   alu_code[5:0]     operation code (NOP = 63)
//   alu_op1_type/alu_op2_type  operand sources: NONE/REG/IMM/PC
//   reg_w_enable      write rd (never for rd = x0)
//   is_load/is_store  memory access flags
//   is_halt           ECALL/EBREAK (any SYSTEM opcode)
//   is_illegal        unknown opcode/funct, only with DECODER_ILLEGAL_EN
//
// Configuration macro: DECODER_ILLEGAL_EN adds the is_illegal output.
// ---------------------------------------------------------------------------
module rv32i_inst_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        inst_valid,
  input  logic [31:0] inst_b,
  output logic        out_valid,
  output logic [4:0]  src1_reg,
  output logic [4:0]  src2_reg,
  output logic [4:0]  dst_reg,
  output logic [31:0] imm,
  output logic [5:0]  alu_code,
  output logic [1:0]  alu_op1_type,
  output logic [1:0]  alu_op2_type,
  output logic        reg_w_enable,
  output logic        is_load,
  output logic        is_store,
  output logic        is_halt
`ifdef DECODER_ILLEGAL_EN
  ,
  output logic        is_illegal
`endif
);

  localparam logic [1:0] OPT_NONE = 2'd0, OPT_REG = 2'd1, OPT_IMM = 2'd2, OPT_PC = 2'd3;

  localparam logic [5:0]
    ALU_ADD  = 6'd0,  ALU_SUB  = 6'd1,  ALU_SLT  = 6'd2,  ALU_SLTU = 6'd3,
    ALU_XOR  = 6'd4,  ALU_OR   = 6'd5,  ALU_AND  = 6'd6,  ALU_SLL  = 6'd7,
    ALU_SRL  = 6'd8,  ALU_SRA  = 6'd9,  ALU_LUI  = 6'd10, ALU_LB   = 6'd11,
    ALU_LH   = 6'd12, ALU_LW   = 6'd13, ALU_LBU  = 6'd14, ALU_LHU  = 6'd15,
    ALU_SB   = 6'd16, ALU_SH   = 6'd17, ALU_SW   = 6'd18, ALU_JAL  = 6'd19,
    ALU_JALR = 6'd20, ALU_BEQ  = 6'd21, ALU_BNE  = 6'd22, ALU_BLT  = 6'd23,
    ALU_BGE  = 6'd24, ALU_BLTU = 6'd25, ALU_BGEU = 6'd26, ALU_NOP  = 6'd63;

  localparam logic [6:0]
    OPC_OP     = 7'b0110011, OPC_OP_IMM = 7'b0010011, OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111, OPC_LOAD   = 7'b0000011, OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011, OPC_JAL    = 7'b1101111, OPC_JALR   = 7'b1100111,
    OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [4:0]  dst;
    logic [31:0] imm;
    logic [5:0]  alu;
    logic [1:0]  op1;
    logic [1:0]  op2;
    logic        wen;
    logic        ld;
    logic        st;
    logic        halt;
  } dec_t;

  // Instruction fields and the five immediate formats.
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = inst_b[6:0];
  assign rd     = inst_b[11:7];
  assign funct3 = inst_b[14:12];
  assign rs1    = inst_b[19:15];
  assign rs2    = inst_b[24:20];
  assign funct7 = inst_b[31:25];

  assign imm_i  = {{20{inst_b[31]}}, inst_b[31:20]};
  assign imm_s  = {{20{inst_b[31]}}, inst_b[31:25], inst_b[11:7]};
  assign imm_b  = {{19{inst_b[31]}}, inst_b[31], inst_b[7], inst_b[30:25], inst_b[11:8], 1'b0};
  assign imm_u  = {inst_b[31:12], 12'b0};
  assign imm_j  = {{11{inst_b[31]}}, inst_b[31], inst_b[19:12], inst_b[20], inst_b[30:21], 1'b0};
  assign imm_sh = {27'b0, inst_b[24:20]};

  dec_t dec;
  logic legal;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can leave it unassigned (no latch).
    dec       = '0;
    dec.alu   = ALU_NOP;
    legal     = 1'b1;

    case (opcode)
      OPC_OP: begin
        dec.src1 = rs1; dec.src2 = rs2; dec.dst = rd;
        dec.op1  = OPT_REG; dec.op2 = OPT_REG; dec.wen = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'b000}: dec.alu = ALU_ADD;
          {7'h20, 3'b000}: dec.alu = ALU_SUB;
          {7'h00, 3'b001}: dec.alu = ALU_SLL;
          {7'h00, 3'b010}: dec.alu = ALU_SLT;
          {7'h00, 3'b011}: dec.alu = ALU_SLTU;
          {7'h00, 3'b100}: dec.alu = ALU_XOR;
          {7'h00, 3'b101}: dec.alu = ALU_SRL;
          {7'h20, 3'b101}: dec.alu = ALU_SRA;
          {7'h00, 3'b110}: dec.alu = ALU_OR;
          {7'h00, 3'b111}: dec.alu = ALU_AND;
          default:         legal   = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec.src1 = rs1; dec.dst = rd; dec.imm = imm_i;
        dec.op1  = OPT_REG; dec.op2 = OPT_IMM; dec.wen = 1'b1;
        case (funct3)
          3'b000: dec.alu = ALU_ADD;
          3'b010: dec.alu = ALU_SLT;
          3'b011: dec.alu = ALU_SLTU;
          3'b100: dec.alu = ALU_XOR;
          3'b110: dec.alu = ALU_OR;
          3'b111: dec.alu = ALU_AND;
          3'b001: begin
            dec.imm = imm_sh;
            if (funct7 == 7'h00) dec.alu = ALU_SLL;
            else                 legal   = 1'b0;
          end
          default: begin // 3'b101: shift right, inst[30] picks arithmetic
            dec.imm = imm_sh;
            if      (funct7 == 7'h00) dec.alu = ALU_SRL;
            else if (funct7 == 7'h20) dec.alu = ALU_SRA;
            else                      legal   = 1'b0;
          end
        endcase
      end
      OPC_LUI: begin
        dec.dst = rd; dec.imm = imm_u; dec.alu = ALU_LUI;
        dec.op1 = OPT_NONE; dec.op2 = OPT_IMM; dec.wen = 1'b1;
      end
      OPC_AUIPC: begin
        dec.dst = rd; dec.imm = imm_u; dec.alu = ALU_ADD;
        dec.op1 = OPT_IMM; dec.op2 = OPT_PC; dec.wen = 1'b1;
      end
      OPC_LOAD: begin
        dec.src1 = rs1; dec.dst = rd; dec.imm = imm_i;
        dec.op1  = OPT_REG; dec.op2 = OPT_IMM; dec.wen = 1'b1; dec.ld = 1'b1;
        case (funct3)
          3'b000:  dec.alu = ALU_LB;
          3'b001:  dec.alu = ALU_LH;
          3'b010:  dec.alu = ALU_LW;
          3'b100:  dec.alu = ALU_LBU;
          3'b101:  dec.alu = ALU_LHU;
          default: legal   = 1'b0;
        endcase
      end
      OPC_STORE: begin
        dec.src1 = rs1; dec.src2 = rs2; dec.imm = imm_s;
        dec.op1  = OPT_REG; dec.op2 = OPT_IMM; dec.st = 1'b1;
        case (funct3)
          3'b000:  dec.alu = ALU_SB;
          3'b001:  dec.alu = ALU_SH;
          3'b010:  dec.alu = ALU_SW;
          default: legal   = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        dec.src1 = rs1; dec.src2 = rs2; dec.imm = imm_b;
        dec.op1  = OPT_REG; dec.op2 = OPT_REG;
        case (funct3)
          3'b000:  dec.alu = ALU_BEQ;
          3'b001:  dec.alu = ALU_BNE;
          3'b100:  dec.alu = ALU_BLT;
          3'b101:  dec.alu = ALU_BGE;
          3'b110:  dec.alu = ALU_BLTU;
          3'b111:  dec.alu = ALU_BGEU;
          default: legal   = 1'b0;
        endcase
      end
      OPC_JAL: begin
        dec.dst = rd; dec.imm = imm_j; dec.alu = ALU_JAL;
        dec.op1 = OPT_NONE; dec.op2 = OPT_PC; dec.wen = 1'b1;
      end
      OPC_JALR: begin
        dec.src1 = rs1; dec.dst = rd; dec.imm = imm_i; dec.alu = ALU_JALR;
        dec.op1  = OPT_REG; dec.op2 = OPT_PC; dec.wen = 1'b1;
        if (funct3 != 3'b000) legal = 1'b0;
      end
      OPC_SYSTEM: dec.halt = 1'b1;
      default:    legal    = 1'b0;
    endcase

    // Illegal encodings and empty slots collapse to a clean NOP.
    if (!legal || !inst_valid) begin
      dec     = '0;
      dec.alu = ALU_NOP;
    end
    // x0 is hard-wired zero, so a write to it is suppressed here.
    dec.wen = dec.wen & (dec.dst != 5'd0);
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the edge and wins over stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      src1_reg     <= '0;
      src2_reg     <= '0;
      dst_reg      <= '0;
      imm          <= '0;
      alu_code     <= ALU_NOP;
      alu_op1_type <= OPT_NONE;
      alu_op2_type <= OPT_NONE;
      reg_w_enable <= 1'b0;
      is_load      <= 1'b0;
      is_store     <= 1'b0;
      is_halt      <= 1'b0;
    end else if (!stall) begin
      out_valid    <= inst_valid;
      src1_reg     <= dec.src1;
      src2_reg     <= dec.src2;
      dst_reg      <= dec.dst;
      imm          <= dec.imm;
      alu_code     <= dec.alu;
      alu_op1_type <= dec.op1;
      alu_op2_type <= dec.op2;
      reg_w_enable <= dec.wen;
      is_load      <= dec.ld;
      is_store     <= dec.st;
      is_halt      <= dec.halt;
    end
  end

`ifdef DECODER_ILLEGAL_EN
  always_ff @(posedge clk) begin
    if (!rst_n)      is_illegal <= 1'b0;
    else if (!stall) is_illegal <= inst_valid & ~legal;
  end
`endif

endmodule

// File: tb/tb_rv32i_inst_decoder.sv
// ---------------------------------------------------------------------------
// tb_rv32i_inst_decoder
//   Directed self-checking bench for rv32i_inst_decoder. Each vector's
//   expected output tuple is hand-computed from the instruction encoding.
//   Tuple order: {valid, src1, src2, dst, imm, alu, op1, op2, wen, ld, st, halt}.
// ---------------------------------------------------------------------------
module tb_rv32i_inst_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] inst_b = '0;
  logic        out_valid;
  logic [4:0]  src1_reg, src2_reg, dst_reg;
  logic [31:0] imm;
  logic [5:0]  alu_code;
  logic [1:0]  alu_op1_type, alu_op2_type;
  logic        reg_w_enable, is_load, is_store, is_halt;
`ifdef DECODER_ILLEGAL_EN
  logic        is_illegal;
`endif

  int passed = 0;
  int total  = 0;

  rv32i_inst_decoder dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .inst_valid(inst_valid), .inst_b(inst_b),
    .out_valid(out_valid), .src1_reg(src1_reg), .src2_reg(src2_reg), .dst_reg(dst_reg),
    .imm(imm), .alu_code(alu_code), .alu_op1_type(alu_op1_type), .alu_op2_type(alu_op2_type),
    .reg_w_enable(reg_w_enable), .is_load(is_load), .is_store(is_store), .is_halt(is_halt)
`ifdef DECODER_ILLEGAL_EN
    , .is_illegal(is_illegal)
`endif
  );

  always #5 clk = ~clk;

  logic [61:0] obs;
  assign obs = {out_valid, src1_reg, src2_reg, dst_reg, imm, alu_code,
                alu_op1_type, alu_op2_type, reg_w_enable, is_load, is_store, is_halt};

  function automatic logic [61:0] e(input int v, input int s1, input int s2, input int d,
                                    input logic [31:0] im, input int alu, input int o1,
                                    input int o2, input int w, input int ld, input int st,
                                    input int h);
    logic [31:0] vv, a, b, c, al, p1, p2, ww, l, s, hh;
    vv = v; a = s1; b = s2; c = d; al = alu; p1 = o1; p2 = o2; ww = w; l = ld; s = st; hh = h;
    return {vv[0], a[4:0], b[4:0], c[4:0], im, al[5:0], p1[1:0], p2[1:0], ww[0], l[0], s[0], hh[0]};
  endfunction

  // Present one instruction after a falling edge, sample 1 ns after the rising edge.
  task automatic drive(input logic [31:0] i, input logic v);
    @(negedge clk);
    inst_b     = i;
    inst_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [61:0] exp_r;
    exp_r = e(0, 0, 0, 0, 32'h0, 63, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    inst_b = 32'h00B50633; inst_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== exp_r) $display("FAIL reset: got %h, expected %h", obs, exp_r);
    else passed++;
`ifdef DECODER_ILLEGAL_EN
    total++;
    if (is_illegal !== 1'b0) $display("FAIL reset_illegal: got %b, expected 0", is_illegal);
    else passed++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    logic [31:0] ins [8];
    logic [61:0] ex  [8];
    ins = '{32'h00B50633, 32'h40B50633, 32'h40B5D7B3, 32'h02B50633,
            32'h4015D793, 32'hFFF00513, 32'h00000013, 32'h808805B7};
    ex[0] = e(1, 10, 11, 12, 32'h0, 0, 1, 1, 1, 0, 0, 0);          // add x12,x10,x11
    ex[1] = e(1, 10, 11, 12, 32'h0, 1, 1, 1, 1, 0, 0, 0);          // sub
    ex[2] = e(1, 11, 11, 15, 32'h0, 9, 1, 1, 1, 0, 0, 0);          // sra
    ex[3] = e(1, 0, 0, 0, 32'h0, 63, 0, 0, 0, 0, 0, 0);            // funct7=1: unknown
    ex[4] = e(1, 11, 0, 15, 32'h1, 9, 1, 2, 1, 0, 0, 0);           // srai x15,x11,1
    ex[5] = e(1, 0, 0, 10, 32'hFFFFFFFF, 0, 1, 2, 1, 0, 0, 0);     // addi x10,x0,-1
    ex[6] = e(1, 0, 0, 0, 32'h0, 0, 1, 2, 0, 0, 0, 0);             // addi x0: no write
    ex[7] = e(1, 0, 0, 11, 32'h80880000, 10, 0, 2, 1, 0, 0, 0);    // lui x11
    for (int k = 0; k < 8; k++) begin
      drive(ins[k], 1'b1);
      total++;
      if (obs !== ex[k]) $display("FAIL alu[%0d] inst=%h: got %h, expected %h", k, ins[k], obs, ex[k]);
      else passed++;
    end
  endtask

  task automatic test_mem_branch();
    logic [31:0] ins [6];
    logic [61:0] ex  [6];
    ins = '{32'h00000817, 32'h00B510A3, 32'h00354683, 32'h00353683,
            32'hFEC584E3, 32'hF8E572E3};
    ex[0] = e(1, 0, 0, 16, 32'h0, 0, 2, 3, 1, 0, 0, 0);            // auipc x16
    ex[1] = e(1, 10, 11, 0, 32'h1, 17, 1, 2, 0, 0, 1, 0);          // sh
    ex[2] = e(1, 10, 0, 13, 32'h3, 14, 1, 2, 1, 1, 0, 0);          // lbu
    ex[3] = e(1, 0, 0, 0, 32'h0, 63, 0, 0, 0, 0, 0, 0);            // load funct3=011
    ex[4] = e(1, 11, 12, 0, 32'hFFFFFFE8, 21, 1, 1, 0, 0, 0, 0);   // beq -24
    ex[5] = e(1, 10, 14, 0, 32'hFFFFFF84, 26, 1, 1, 0, 0, 0, 0);   // bgeu -124
    for (int k = 0; k < 6; k++) begin
      drive(ins[k], 1'b1);
      total++;
      if (obs !== ex[k]) $display("FAIL mem_branch[%0d] inst=%h: got %h, expected %h", k, ins[k], obs, ex[k]);
      else passed++;
    end
  endtask

  task automatic test_jump_system();
    logic [31:0] ins [6];
    logic [61:0] ex  [6];
    ins = '{32'h00C0006F, 32'h008000EF, 32'h00C08067, 32'h00000073,
            32'hFFFFFFFF, 32'h00B50633};
    ex[0] = e(1, 0, 0, 0, 32'd12, 19, 0, 3, 0, 0, 0, 0);           // jal x0,12
    ex[1] = e(1, 0, 0, 1, 32'd8, 19, 0, 3, 1, 0, 0, 0);            // jal x1,8
    ex[2] = e(1, 1, 0, 0, 32'd12, 20, 1, 3, 0, 0, 0, 0);           // jalr x0,12(x1)
    ex[3] = e(1, 0, 0, 0, 32'h0, 63, 0, 0, 0, 0, 0, 1);            // ecall
    ex[4] = e(1, 0, 0, 0, 32'h0, 63, 0, 0, 0, 0, 0, 0);            // unknown opcode
    ex[5] = e(0, 0, 0, 0, 32'h0, 63, 0, 0, 0, 0, 0, 0);            // inst_valid=0
    for (int k = 0; k < 6; k++) begin
      drive(ins[k], (k != 5));
      total++;
      if (obs !== ex[k]) $display("FAIL jump_sys[%0d] inst=%h: got %h, expected %h", k, ins[k], obs, ex[k]);
      else passed++;
`ifdef DECODER_ILLEGAL_EN
      total++;
      if (is_illegal !== (k == 4)) $display("FAIL illegal[%0d]: got %b, expected %b", k, is_illegal, (k == 4));
      else passed++;
`endif
    end
  endtask

  task automatic test_stall_latency();
    logic [61:0] ex_add, ex_lui, ex_rst;
    ex_add = e(1, 10, 11, 12, 32'h0, 0, 1, 1, 1, 0, 0, 0);
    ex_lui = e(1, 0, 0, 11, 32'h80880000, 10, 0, 2, 1, 0, 0, 0);
    ex_rst = e(0, 0, 0, 0, 32'h0, 63, 0, 0, 0, 0, 0, 0);
    drive(32'h00B50633, 1'b1);
    // New input must not reach the outputs before the next edge.
    @(negedge clk);
    inst_b = 32'h808805B7;
    #1;
    total++;
    if (obs !== ex_add) $display("FAIL latency_pre_edge: got %h, expected %h", obs, ex_add);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (obs !== ex_lui) $display("FAIL latency_post_edge: got %h, expected %h", obs, ex_lui);
    else passed++;
    // Stall holds across two edges while inst_b changes.
    drive(32'h00B50633, 1'b1);
    @(negedge clk);
    stall = 1'b1; inst_b = 32'h808805B7;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== ex_add) $display("FAIL stall_hold: got %h, expected %h", obs, ex_add);
    else passed++;
    @(negedge clk);
    stall = 1'b0;
    @(posedge clk); #1;
    total++;
    if (obs !== ex_lui) $display("FAIL stall_release: got %h, expected %h", obs, ex_lui);
    else passed++;
    // Reset overrides stall.
    @(negedge clk);
    stall = 1'b1; rst_n = 1'b0; inst_b = 32'h00B50633;
    @(posedge clk); #1;
    total++;
    if (obs !== ex_rst) $display("FAIL reset_over_stall: got %h, expected %h", obs, ex_rst);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem_branch();
    test_jump_system();
    test_stall_latency();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
